// File: rtl/hilo_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the HI/LO multiplier issue path:
//               EX-stage op encodings, wrapper LO/HI write-port encodings,
//               the wrapper latency constant and the controller state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // EX-stage operation codes
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MFHI  = 3'd3,
    OP_MFLO  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  // Wrapper LO/HI write-port select
  localparam int                              LOHI_WRITE_OPT_WIDTH = 2;
  localparam logic [LOHI_WRITE_OPT_WIDTH-1:0] LOHI_WRITE_NONE      = 2'b00;
  localparam logic [LOHI_WRITE_OPT_WIDTH-1:0] LOHI_WRITE_LO        = 2'b01;
  localparam logic [LOHI_WRITE_OPT_WIDTH-1:0] LOHI_WRITE_HI        = 2'b10;

  // Wrapper latency: its counter runs 0..WAIT_CYCLE before ready rises
  localparam int WAIT_CYCLE = 14;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_FIX_LO = 3'd3,
    ST_FIX_HI = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/hilo_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hilo_issue_ctrl_if
// Description : Bundles the EX-stage request/response signals and the HI/LO
//               multiplier wrapper signals seen by the issue controller.
//   master : the issue controller (consumes ops, drives the wrapper)
//   slave  : the environment (EX stage + wrapper)
//   op_valid/op/rs_data/rt_data : EX-stage op and operands
//   stall/rd_valid/rd_data      : EX-stage back-pressure and read data
//   mul_start/mul_opr1/mul_opr2 : wrapper start (edge) and operands
//   mul_write_opt/mul_write_data: wrapper LO/HI write port
//   mul_result/mul_ready        : wrapper HI:LO and result valid
// Revision    : 1.0 - initial release
// ============================================================================
interface hilo_issue_ctrl_if;
  import muldiv_pkg::*;

  logic                            op_valid;
  logic [2:0]                      op;
  logic [31:0]                     rs_data;
  logic [31:0]                     rt_data;
  logic                            stall;
  logic                            rd_valid;
  logic [31:0]                     rd_data;
  logic                            mul_start;
  logic [31:0]                     mul_opr1;
  logic [31:0]                     mul_opr2;
  logic [63:0]                     mul_result;
  logic [LOHI_WRITE_OPT_WIDTH-1:0] mul_write_opt;
  logic [31:0]                     mul_write_data;
  logic                            mul_ready;

  modport master (
    input  op_valid, op, rs_data, rt_data, mul_result, mul_ready,
    output stall, rd_valid, rd_data, mul_start, mul_opr1, mul_opr2,
           mul_write_opt, mul_write_data
  );

  modport slave (
    output op_valid, op, rs_data, rt_data, mul_result, mul_ready,
    input  stall, rd_valid, rd_data, mul_start, mul_opr1, mul_opr2,
           mul_write_opt, mul_write_data
  );

endinterface
`default_nettype wire

// File: rtl/hilo_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hilo_issue_ctrl
// Description : Pipeline-side initiator for the HI/LO multiplier wrapper.
//               Accepts MULT/MULTU/MFHI/MFLO/MTHI/MTLO, holds operands for the
//               wrapper, pulses its edge-triggered start, stalls until ready
//               and serves HI/LO reads/writes.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : hilo_issue_ctrl_if.master (EX-stage + wrapper signals)
// Build option : MULT_SIGNED_EN - signed MULT via magnitudes plus a two-cycle
//                negated write-back (FIX_LO/FIX_HI). Undefined: MULT == MULTU.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_issue_ctrl #(
  parameter int WAIT_CYCLE = muldiv_pkg::WAIT_CYCLE
) (
  input  wire                clk,
  input  wire                rst,
  hilo_issue_ctrl_if.master  bus
);
  import muldiv_pkg::*;

  // The wrapper's start-to-ready sequence needs a non-zero latency
  if (WAIT_CYCLE < 1) begin : g_wait_cycle_chk
    $error("hilo_issue_ctrl: WAIT_CYCLE must be at least 1");
  end

  op_e         op_w;
  logic        hilo_op;
  logic        accept;
  state_e      state_q, state_d;
  logic [31:0] opr1_q, opr1_d;
  logic [31:0] opr2_q, opr2_d;
`ifdef MULT_SIGNED_EN
  logic        neg_q, neg_d;
  logic        signed_q, signed_d;
  logic [63:0] corr_q, corr_d;
`endif

  assign op_w    = op_e'(bus.op);
  assign hilo_op = bus.op_valid && (op_w != OP_NONE);
  // Only IDLE with a settled wrapper can take a new HI/LO op
  assign bus.stall = hilo_op && !((state_q == ST_IDLE) && bus.mul_ready);
  assign accept    = hilo_op && !bus.stall;

  assign bus.mul_opr1 = opr1_q;
  assign bus.mul_opr2 = opr2_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opr1_q   <= '0;
      opr2_q   <= '0;
`ifdef MULT_SIGNED_EN
      neg_q    <= 1'b0;
      signed_q <= 1'b0;
      corr_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      opr1_q   <= opr1_d;
      opr2_q   <= opr2_d;
`ifdef MULT_SIGNED_EN
      neg_q    <= neg_d;
      signed_q <= signed_d;
      corr_q   <= corr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    opr1_d   = opr1_q;
    opr2_d   = opr2_q;
`ifdef MULT_SIGNED_EN
    neg_d    = neg_q;
    signed_d = signed_q;
    corr_d   = corr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept && ((op_w == OP_MULT) || (op_w == OP_MULTU))) begin
          opr1_d  = bus.rs_data;
          opr2_d  = bus.rt_data;
`ifdef MULT_SIGNED_EN
          signed_d = (op_w == OP_MULT);
          neg_d    = signed_d && (bus.rs_data[31] ^ bus.rt_data[31]);
          if (signed_d) begin
            // Two's-complement magnitude; 0x80000000 maps onto itself,
            // which is exactly 2^31 when read as unsigned.
            opr1_d = bus.rs_data[31] ? (~bus.rs_data + 32'd1) : bus.rs_data;
            opr2_d = bus.rt_data[31] ? (~bus.rt_data + 32'd1) : bus.rt_data;
          end
`endif
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.mul_ready) begin
`ifdef MULT_SIGNED_EN
          if (signed_q && neg_q) begin
            // Captured now: the LO write in FIX_LO alters mul_result
            corr_d  = ~bus.mul_result + 64'd1;
            state_d = ST_FIX_LO;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef MULT_SIGNED_EN
      ST_FIX_LO: state_d = ST_FIX_HI;
      ST_FIX_HI: state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic; FIX writes and MT writes never coincide since MT is
  // only accepted in IDLE.
  always_comb begin
    bus.mul_start      = (state_q == ST_ISSUE);
    bus.mul_write_opt  = LOHI_WRITE_NONE;
    bus.mul_write_data = '0;
    bus.rd_valid       = 1'b0;
    bus.rd_data        = '0;
`ifdef MULT_SIGNED_EN
    if (state_q == ST_FIX_LO) begin
      bus.mul_write_opt  = LOHI_WRITE_LO;
      bus.mul_write_data = corr_q[31:0];
    end else if (state_q == ST_FIX_HI) begin
      bus.mul_write_opt  = LOHI_WRITE_HI;
      bus.mul_write_data = corr_q[63:32];
    end
`endif
    if (accept) begin
      case (op_w)
        OP_MTLO: begin
          bus.mul_write_opt  = LOHI_WRITE_LO;
          bus.mul_write_data = bus.rs_data;
        end
        OP_MTHI: begin
          bus.mul_write_opt  = LOHI_WRITE_HI;
          bus.mul_write_data = bus.rs_data;
        end
        OP_MFHI: begin
          bus.rd_valid = 1'b1;
          bus.rd_data  = bus.mul_result[63:32];
        end
        OP_MFLO: begin
          bus.rd_valid = 1'b1;
          bus.rd_data  = bus.mul_result[31:0];
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hilo_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_issue_ctrl
// Description : Self-checking bench for hilo_issue_ctrl with a behavioural
//               HI/LO multiplier wrapper and a read-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_issue_ctrl;
  import muldiv_pkg::*;

  localparam int WAIT_CYCLE_TB = muldiv_pkg::WAIT_CYCLE;
  localparam int MUL_LAT       = WAIT_CYCLE_TB + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   start_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hilo_issue_ctrl_if bus();

  hilo_issue_ctrl #(.WAIT_CYCLE(WAIT_CYCLE_TB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural wrapper: rising start latches the product, counter runs
  // 0..WAIT_CYCLE, then ready rises with the product on HI:LO.
  logic [63:0] wr_hilo  = '0;
  logic [63:0] wr_prod  = '0;
  logic        wr_ready = 1'b1;
  logic        wr_busy  = 1'b0;
  logic        wr_start = 1'b0;
  int          wr_cnt   = 0;

  assign bus.mul_result = wr_hilo;
  assign bus.mul_ready  = wr_ready;

  always @(posedge clk) begin
    wr_start <= bus.mul_start;
    if (bus.mul_start && !wr_start) begin
      wr_busy  <= 1'b1;
      wr_cnt   <= 0;
      wr_ready <= 1'b0;
      wr_prod  <= {32'd0, bus.mul_opr1} * {32'd0, bus.mul_opr2};
    end else if (wr_busy) begin
      if (wr_cnt == WAIT_CYCLE_TB) begin
        wr_ready <= 1'b1;
        wr_busy  <= 1'b0;
        wr_hilo  <= wr_prod;
      end else begin
        wr_cnt <= wr_cnt + 1;
      end
    end
    if (bus.mul_write_opt == LOHI_WRITE_LO) wr_hilo[31:0]  <= bus.mul_write_data;
    if (bus.mul_write_opt == LOHI_WRITE_HI) wr_hilo[63:32] <= bus.mul_write_data;
  end

  task automatic check_value(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and write-port log
  typedef struct {
    int          c;
    logic [1:0]  opt;
    logic [31:0] d;
  } wr_t;

  logic [31:0] exp_q[$];
  wr_t         wr_log[$];
  logic [63:0] ref_hilo = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rd_valid) begin
        if (exp_q.size() == 0) check_value("rd_unexpected", 64'd1, 64'd0);
        else                   check_value("rd_data", 64'(bus.rd_data), 64'(exp_q.pop_front()));
      end
      if (bus.mul_start) start_cnt++;
      if (bus.mul_write_opt != LOHI_WRITE_NONE)
        wr_log.push_back('{c: cyc, opt: bus.mul_write_opt, d: bus.mul_write_data});
    end
  end

  function automatic logic [31:0] mag(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  // Drive one op from posedge+1, hold until accepted, return accept cycle.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, output int acc);
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.rs_data  = a;
    bus.rt_data  = b;
    case (o)
      OP_MULTU: ref_hilo = {32'd0, a} * {32'd0, b};
`ifdef MULT_SIGNED_EN
      OP_MULT:  ref_hilo = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
`else
      OP_MULT:  ref_hilo = {32'd0, a} * {32'd0, b};
`endif
      OP_MFHI:  exp_q.push_back(ref_hilo[63:32]);
      OP_MFLO:  exp_q.push_back(ref_hilo[31:0]);
      OP_MTHI:  ref_hilo[63:32] = a;
      OP_MTLO:  ref_hilo[31:0]  = a;
      default: ;
    endcase
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.stall) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) check_value("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.op       = OP_NONE;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2;
    bus.op_valid = 1'b0;
    bus.op       = OP_NONE;
    bus.rs_data  = '0;
    bus.rt_data  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_value("rst_start", 64'(bus.mul_start), 64'd0);
    check_value("rst_opr1",  64'(bus.mul_opr1), 64'd0);
    check_value("rst_opr2",  64'(bus.mul_opr2), 64'd0);
    check_value("rst_wopt",  64'(bus.mul_write_opt), 64'd0);
    check_value("rst_wdata", 64'(bus.mul_write_data), 64'd0);
    check_value("rst_stall", 64'(bus.stall), 64'd0);
    check_value("rst_rdv",   64'(bus.rd_valid), 64'd0);
    check_value("rst_rdd",   64'(bus.rd_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // MULTU max x max, then MFHI/MFLO
    wr_log.delete(); start_cnt = 0;
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c0);
    check_value("multu_opr1", 64'(bus.mul_opr1), 64'hFFFF_FFFF);
    do_op(OP_MFHI, 32'd0, 32'd0, c1);
    check_value("multu_mfhi_lat", 64'(c1 - c0), 64'(MUL_LAT));
    do_op(OP_MFLO, 32'd0, 32'd0, c2);
    check_value("multu_mflo_lat", 64'(c2 - c1), 64'd1);
    check_value("multu_start_cnt", 64'(start_cnt), 64'd1);
    check_value("multu_no_wr", 64'(wr_log.size()), 64'd0);

    // Negative signed MULT with FIX write-back
    wr_log.delete();
    do_op(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, c0);
`ifdef MULT_SIGNED_EN
    check_value("mult_opr1", 64'(bus.mul_opr1), 64'd3);
`else
    check_value("mult_opr1", 64'(bus.mul_opr1), 64'hFFFF_FFFD);
`endif
    check_value("mult_opr2", 64'(bus.mul_opr2), 64'd5);
    do_op(OP_MFHI, 32'd0, 32'd0, c1);
    do_op(OP_MFLO, 32'd0, 32'd0, c2);
`ifdef MULT_SIGNED_EN
    check_value("mult_mfhi_lat", 64'(c1 - c0), 64'(MUL_LAT + 2));
    check_value("mult_fix_cnt", 64'(wr_log.size()), 64'd2);
    if (wr_log.size() == 2) begin
      check_value("fix_lo_cyc",  64'(wr_log[0].c - c0), 64'(MUL_LAT));
      check_value("fix_lo_opt",  64'(wr_log[0].opt), 64'(LOHI_WRITE_LO));
      check_value("fix_lo_data", 64'(wr_log[0].d), 64'hFFFF_FFF1);
      check_value("fix_hi_cyc",  64'(wr_log[1].c - c0), 64'(MUL_LAT + 1));
      check_value("fix_hi_opt",  64'(wr_log[1].opt), 64'(LOHI_WRITE_HI));
      check_value("fix_hi_data", 64'(wr_log[1].d), 64'hFFFF_FFFF);
    end
`else
    check_value("mult_mfhi_lat", 64'(c1 - c0), 64'(MUL_LAT));
    check_value("mult_fix_cnt", 64'(wr_log.size()), 64'd0);
`endif

    // MULT min x min: magnitudes stay 0x80000000, no FIX
    wr_log.delete();
    do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, c0);
    check_value("min_opr1", 64'(bus.mul_opr1), 64'h8000_0000);
    check_value("min_opr2", 64'(bus.mul_opr2), 64'h8000_0000);
    do_op(OP_MFHI, 32'd0, 32'd0, c1);
    do_op(OP_MFLO, 32'd0, 32'd0, c2);
    check_value("min_lat", 64'(c1 - c0), 64'(MUL_LAT));
    check_value("min_no_wr", 64'(wr_log.size()), 64'd0);

    // MTLO then MFLO back-to-back
    wr_log.delete();
    do_op(OP_MTLO, 32'h0000_1234, 32'd0, c0);
    do_op(OP_MFLO, 32'd0, 32'd0, c1);
    check_value("mt_mf_lat", 64'(c1 - c0), 64'd1);
    check_value("mtlo_wr_cnt", 64'(wr_log.size()), 64'd1);
    if (wr_log.size() == 1) begin
      check_value("mtlo_cyc",  64'(wr_log[0].c - c0), 64'd0);
      check_value("mtlo_opt",  64'(wr_log[0].opt), 64'(LOHI_WRITE_LO));
      check_value("mtlo_data", 64'(wr_log[0].d), 64'h1234);
    end

    // Reset while in WAIT; wrapper keeps running on magnitudes
    do_op(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, c0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_value("mrst_start", 64'(bus.mul_start), 64'd0);
    check_value("mrst_opr1",  64'(bus.mul_opr1), 64'd0);
    check_value("mrst_opr2",  64'(bus.mul_opr2), 64'd0);
    check_value("mrst_wopt",  64'(bus.mul_write_opt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef MULT_SIGNED_EN
    ref_hilo = {32'd0, mag(32'hFFFF_FFFE)} * 64'd3;
`else
    ref_hilo = {32'd0, 32'hFFFF_FFFE} * 64'd3;
`endif
    wr_log.delete();
    do_op(OP_MFLO, 32'd0, 32'd0, c1);
    check_value("mrst_mflo_lat", 64'(c1 - c0), 64'(MUL_LAT - 1));
    do_op(OP_MFHI, 32'd0, 32'd0, c2);
    check_value("mrst_no_wr", 64'(wr_log.size()), 64'd0);

    // MULTU, NONE ops never stall, MTHI held until IDLE
    do_op(OP_MULTU, 32'd7, 32'd9, c0);
    for (int i = 1; i <= 3; i++) begin
      do_op(OP_NONE, 32'd0, 32'd0, c1);
      check_value("none_no_stall", 64'(c1 - c0), 64'(i));
    end
    do_op(OP_MTHI, 32'hABCD_0000, 32'd0, c1);
    check_value("mthi_lat", 64'(c1 - c0), 64'(MUL_LAT));
    do_op(OP_MFHI, 32'd0, 32'd0, c2);
    do_op(OP_MFLO, 32'd0, 32'd0, c2);

    repeat (2) @(posedge clk);
    check_value("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
